reg_file_2r1w: RTL
==================

# reg_file_2r1w

Operand register file that sources the two 32-bit ALU operands `reg_s1`/`reg_s2` and sinks the result `reg_d` written back by the bitwise units, such as the 32-bit XOR array. It holds 32 general registers and accepts one write-back per cycle. It serves operand reads through a valid/ready request/response handshake with a registered response. Register 0 can be hard-wired to zero.

## Interface
- `DATA_W`, default 32: register and operand width.
- `ADDR_W`, default 5: register address width; depth is 2**ADDR_W.
- `ZERO_REG`, default 1: when 1, register 0 always reads 0 and ignores writes.

Ports:
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `rd_req_valid` input, 1 bit: an operand read request is present.
- `rd_req_ready` output, 1 bit: the block can accept a read request this cycle.
- `rs1_addr` input, ADDR_W bits: source-1 register address.
- `rs2_addr` input, ADDR_W bits: source-2 register address.
- `rd_rsp_valid` output, 1 bit: `reg_s1`/`reg_s2` hold a valid operand pair.
- `rd_rsp_ready` input, 1 bit: the consumer (ALU) accepts the operand pair.
- `reg_s1` output, DATA_W bits: source-1 operand.
- `reg_s2` output, DATA_W bits: source-2 operand.
- `wb_valid` input, 1 bit: write-back strobe.
- `wb_addr` input, ADDR_W bits: destination register address.
- `reg_d` input, DATA_W bits: write-back data (the ALU result).

## Operation
- Reset (async assert) clears all registers to 0, `rd_rsp_valid`=0, `reg_s1`=`reg_s2`=0, `rd_req_ready`=1.
- Response stage FSM has two states:
  - EMPTY: `rd_rsp_valid`=0.
  - FULL: `rd_rsp_valid`=1.
- `rd_req_ready` = EMPTY or `rd_rsp_ready`. This is a combinational path from `rd_rsp_ready` to `rd_req_ready`; there is no path from any valid to its own ready.
- A request is accepted when `rd_req_valid` and `rd_req_ready`. The next state is FULL, with `reg_s1`/`reg_s2` loaded from the array.
- FULL with `rd_rsp_ready`=1 and no new request: go to EMPTY; outputs keep their last value.
- FULL with `rd_rsp_ready`=1 and a new request: stay FULL and load the new pair (back-to-back, one pair per cycle).
- FULL with `rd_rsp_ready`=0: hold the state, and hold `reg_s1`/`reg_s2` bit-stable. A write-back to a held source register does NOT update the held operands.
- Write: on `wb_valid`, `reg_d` is stored at `wb_addr` on the clock edge. Writes are independent of the read handshake and are never back-pressured.
- With `ZERO_REG`=1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, including under bypass.
- `rs1_addr`==`rs2_addr` is legal; both outputs return the same value.
- Mid-operation reset discards the pending response and clears all contents; no partial write survives.

## Timing
- Read latency: 1 cycle from acceptance to `rd_rsp_valid`.
- Throughput: 1 operand pair per cycle while `rd_rsp_ready`=1.
- Write is visible to a request accepted on the following cycle or later.
- Same-cycle write and accepted read of the same address: the result depends on the configuration macro below.

## Configuration
- Macro: `REG_FILE_2R1W_BYPASS_EN`.
- Defined: a read accepted in the same cycle as `wb_valid` to a matching nonzero address returns `reg_d`. The bypass applies per port.
- Undefined: such a read returns the pre-write (old) register value. There is no bypass mux.

## Structure
- Shared package `reg_file_pkg` holds:
  - `DATA_W`/`ADDR_W` defaults;
  - `ZERO_ADDR` constant;
  - `rsp_state_t` enum (EMPTY, FULL).
- Sub-module `reg_file_read_port`: one array read mux plus the bypass compare, producing one operand word. It is instantiated twice (s1, s2).
- The top level owns the storage array, the write logic and the response FSM and registers.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream, release, request rs1=5/rs2=9 → after 1 cycle `rd_rsp_valid`=1, `reg_s1`=0, `reg_s2`=0.
- **Write/read:** write 0xDEADBEEF to r3, next cycle request rs1=3/rs2=0 → `reg_s1`=0xDEADBEEF, `reg_s2`=0. Write 0x1234 to r0 → later read of r0 returns 0.
- **Stall:** response FULL with r7=0xAAAA5555, hold `rd_rsp_ready`=0 for 4 cycles while writing 0x0F0F to r7 → `reg_s1` stays 0xAAAA5555 and `rd_req_ready`=0; release → next request of r7 returns 0x0F0F.
- **Back-to-back:** 8 consecutive requests with `rd_rsp_ready`=1 → 8 consecutive valid cycles, correct pairs in order, no bubbles.
- **Same-cycle hazard:** write 0x55 to r10 while accepting a request for rs1=10 (old value 0x11) → response 0x55 with `REG_FILE_2R1W_BYPASS_EN`, 0x11 without.
- **Result loop:** read r1=0xFFFF0000 and r2=0x00FFFF00, feed the XOR result 0xFF00FF00 back to r4, read r4 → 0xFF00FF00.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared definitions for the 2-read/1-write operand register file:
// default widths, the hard-wired zero register address and the response-stage state type.
package reg_file_pkg;

   localparam int REGF_DATA_W = 32;
   localparam int REGF_ADDR_W = 5;

   localparam logic [31:0] ZERO_ADDR = 32'd0;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } rsp_state_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One operand read port: array read mux plus the optional same-cycle write-back forwarding
// (compiled in when REG_FILE_2R1W_BYPASS_EN is defined).
module reg_file_read_port
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = REGF_DATA_W,
   parameter int ADDR_W   = REGF_ADDR_W,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs_i,
   input  logic [ADDR_W-1:0]                  rd_addr_i,
   input  logic                               wb_valid_i,
   input  logic [ADDR_W-1:0]                  wb_addr_i,
   input  logic [DATA_W-1:0]                  wb_data_i,
   output logic [DATA_W-1:0]                  rd_data_o
);

   logic rd_is_zero;

   assign rd_is_zero = ZERO_REG && (rd_addr_i == ADDR_W'(ZERO_ADDR));

`ifdef REG_FILE_2R1W_BYPASS_EN
   logic fwd_hit;

   // Forwarding never overrides the hard-wired zero register.
   assign fwd_hit = wb_valid_i && (wb_addr_i == rd_addr_i) && !rd_is_zero;

   always_comb begin
      if (rd_is_zero) begin
         rd_data_o = '0;
      end else if (fwd_hit) begin
         rd_data_o = wb_data_i;
      end else begin
         rd_data_o = regs_i[rd_addr_i];
      end
   end
`else
   logic unused_wb;

   assign unused_wb = ^{wb_valid_i, wb_addr_i, wb_data_i};

   always_comb begin
      if (rd_is_zero) begin
         rd_data_o = '0;
      end else begin
         rd_data_o = regs_i[rd_addr_i];
      end
   end
`endif

endmodule

// File: rtl/reg_file_2r1w.sv
// 32-entry operand register file: two read ports behind a registered valid/ready response stage,
// one unconditional write-back port. Same-cycle forwarding is enabled by REG_FILE_2R1W_BYPASS_EN.
module reg_file_2r1w
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = REGF_DATA_W,
   parameter int ADDR_W   = REGF_ADDR_W,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_req_valid,
   output logic              rd_req_ready,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              rd_rsp_valid,
   input  logic              rd_rsp_ready,
   output logic [DATA_W-1:0] reg_s1,
   output logic [DATA_W-1:0] reg_s2,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] reg_d
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] mem_q;
   logic [DEPTH-1:0][DATA_W-1:0] mem_d;

   rsp_state_t        state_q;
   logic [DATA_W-1:0] s1_q;
   logic [DATA_W-1:0] s2_q;
   logic [DATA_W-1:0] s1_rd;
   logic [DATA_W-1:0] s2_rd;
   logic              req_acc;
   logic              wb_en;

   // Writes to the zero register are dropped so storage never holds a nonzero r0.
   assign wb_en = wb_valid && !(ZERO_REG && (wb_addr == ADDR_W'(ZERO_ADDR)));

   always_comb begin
      mem_d = mem_q;
      if (wb_en) begin
         mem_d[wb_addr] = reg_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   reg_file_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_port_s1 (
      .regs_i     (mem_q),
      .rd_addr_i  (rs1_addr),
      .wb_valid_i (wb_valid),
      .wb_addr_i  (wb_addr),
      .wb_data_i  (reg_d),
      .rd_data_o  (s1_rd)
   );

   reg_file_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_port_s2 (
      .regs_i     (mem_q),
      .rd_addr_i  (rs2_addr),
      .wb_valid_i (wb_valid),
      .wb_addr_i  (wb_addr),
      .wb_data_i  (reg_d),
      .rd_data_o  (s2_rd)
   );

   // Ready depends only on the stage state and downstream ready, never on rd_req_valid.
   assign rd_req_ready = (state_q == EMPTY) || rd_rsp_ready;
   assign req_acc      = rd_req_valid && rd_req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         s1_q    <= '0;
         s2_q    <= '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (req_acc) begin
                  state_q <= FULL;
                  s1_q    <= s1_rd;
                  s2_q    <= s2_rd;
               end
            end
            FULL: begin
               if (rd_rsp_ready) begin
                  if (req_acc) begin
                     s1_q <= s1_rd;
                     s2_q <= s2_rd;
                  end else begin
                     state_q <= EMPTY;
                  end
               end
            end
         endcase
      end
   end

   assign rd_rsp_valid = (state_q == FULL);
   assign reg_s1       = s1_q;
   assign reg_s2       = s2_q;

   a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (rd_rsp_valid && !rd_rsp_ready) |=> (rd_rsp_valid && $stable(reg_s1) && $stable(reg_s2)));

   a_zero_reg: assert property (@(posedge clk) disable iff (!rst_n)
      !ZERO_REG || (mem_q[0] == '0));

endmodule
